// File: rtl/genius_pkg.sv
// Shared state codes, control-word layout and output decode for the game controller.
// The display/debug logic reads the same state codes from here.
package genius_pkg;

  localparam logic [2:0] ST_INIT       = 3'd0;
  localparam logic [2:0] ST_SETUP      = 3'd1;
  localparam logic [2:0] ST_PLAY_FPGA  = 3'd2;
  localparam logic [2:0] ST_PLAY_USER  = 3'd3;
  localparam logic [2:0] ST_CHECK      = 3'd4;
  localparam logic [2:0] ST_NEXT_ROUND = 3'd5;
  localparam logic [2:0] ST_ROUND_CHK  = 3'd6;
  localparam logic [2:0] ST_RESULT     = 3'd7;

  typedef enum logic [2:0] {
    INIT       = ST_INIT,
    SETUP      = ST_SETUP,
    PLAY_FPGA  = ST_PLAY_FPGA,
    PLAY_USER  = ST_PLAY_USER,
    CHECK      = ST_CHECK,
    NEXT_ROUND = ST_NEXT_ROUND,
    ROUND_CHK  = ST_ROUND_CHK,
    RESULT     = ST_RESULT
  } state_t;

  typedef struct packed {
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Moore decode: every control output is a pure function of the state.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      INIT:       begin c.r1 = 1'b1; c.r2 = 1'b1; end
      SETUP:      c.e1 = 1'b1;
      PLAY_FPGA:  c.e3 = 1'b1;
      PLAY_USER:  c.e2 = 1'b1;
      NEXT_ROUND: begin c.e4 = 1'b1; c.r2 = 1'b1; end
      RESULT:     c.sel = 1'b1;
      default:    c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/controller_if.sv
// Control/status bundle between the game controller (master) and the datapath (slave).
interface controller_if;

  logic       enter_n;
  logic       end_FPGA;
  logic       end_User;
  logic       end_time;
  logic       win;
  logic       match;

  logic       R1;
  logic       R2;
  logic       E1;
  logic       E2;
  logic       E3;
  logic       E4;
  logic       SEL;
  logic [2:0] state_o;

  modport master (
    input  enter_n, end_FPGA, end_User, end_time, win, match,
    output R1, R2, E1, E2, E3, E4, SEL, state_o
  );

  modport slave (
    output enter_n, end_FPGA, end_User, end_time, win, match,
    input  R1, R2, E1, E2, E3, E4, SEL, state_o
  );

endinterface

// File: rtl/key_press_detect.sv
// Two-flop synchroniser plus falling-edge detector for an active-low pushbutton.
// Produces a registered one-cycle press pulse three clocks after the key falls.
module key_press_detect (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  logic       sync0_q;
  logic       sync1_q;
  logic       prev_q;
  logic [2:0] valid_q;

  // valid_q marks when prev_q holds a real key sample rather than its reset
  // value, so a key held down across reset release never looks like a fall.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q <= 1'b1;
      sync1_q <= 1'b1;
      prev_q  <= 1'b1;
      valid_q <= '0;
      press   <= 1'b0;
    end else begin
      sync0_q <= key_n;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
      valid_q <= {valid_q[1:0], 1'b1};
      press   <= valid_q[2] & prev_q & ~sync1_q;
    end
  end

endmodule

// File: rtl/controller.sv
// Moore FSM sequencing setup, FPGA playback, user entry, checking and results.
// Control outputs are registered from the next state so they align with state_o.
module controller
  import genius_pkg::*;
(
  input  logic            CLOCK_50,
  input  logic            reset_n,
  controller_if.master    bus
);

  logic   press;
  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;

  key_press_detect u_kpd (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .key_n    (bus.enter_n),
    .press    (press)
  );

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:       state_d = SETUP;
      SETUP:      if (press) state_d = PLAY_FPGA;
      PLAY_FPGA:  if (bus.end_FPGA) state_d = PLAY_USER;
      PLAY_USER: begin
        if (bus.end_time)      state_d = RESULT;
        else if (bus.end_User) state_d = CHECK;
      end
      CHECK:      state_d = bus.match ? NEXT_ROUND : RESULT;
      NEXT_ROUND: state_d = ROUND_CHK;
      ROUND_CHK:  state_d = bus.win ? RESULT : PLAY_FPGA;
      RESULT:     if (press) state_d = INIT;
      default:    state_d = INIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      ctrl_q  <= decode_ctrl(INIT);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  assign bus.R1      = ctrl_q.r1;
  assign bus.R2      = ctrl_q.r2;
  assign bus.E1      = ctrl_q.e1;
  assign bus.E2      = ctrl_q.e2;
  assign bus.E3      = ctrl_q.e3;
  assign bus.E4      = ctrl_q.e4;
  assign bus.SEL     = ctrl_q.sel;
  assign bus.state_o = state_q;

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 CLOCK_50  input  1  system clock, 50 MHz, all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enter_n  input  1  start/confirm pushbutton, active-low, asynchronous to CLOCK_50.
REQ-005 end_FPGA  input  1  FPGA sequence playback finished.
REQ-006 end_User  input  1  user entry count reached the current round.
REQ-007 end_time  input  1  user response timer expired.
REQ-008 win  input  1  round counter reached the configured final round.
REQ-009 match  input  1  user sequence equals FPGA sequence.
REQ-010 R1  output  1  game reset: setup register, round counter and clock divider.
REQ-011 R2  output  1  round reset: timer, FPGA/user counters and sequence registers.
REQ-012 E1  output  1  setup capture enable.
REQ-013 E2  output  1  user-entry and timer enable.
REQ-014 E3  output  1  FPGA sequence playback enable.
REQ-015 E4  output  1  round counter increment enable.
REQ-016 SEL  output  1  display select; 1 shows the result screen.
REQ-017 state_o  output  3  current state code, for debug LEDs.

Function
REQ-018 enter_n SHALL pass through a two-flop synchroniser, then a falling-edge detector, to produce a one-cycle press pulse 3 cycles after the input falls; holding the key SHALL yield exactly one pulse.
REQ-019 The FSM SHALL be Moore-type with states INIT=0, SETUP=1, PLAY_FPGA=2, PLAY_USER=3, CHECK=4, NEXT_ROUND=5, ROUND_CHK=6, RESULT=7.
REQ-020 All outputs SHALL be registered: decoded from the next state, so they are valid in the same cycle the state register holds that state.
REQ-021 INIT: R1=1, R2=1, others 0; next state SETUP unconditionally.
REQ-022 SETUP: E1=1; on press go to PLAY_FPGA, else stay.
REQ-023 PLAY_FPGA: E3=1; on end_FPGA go to PLAY_USER.
REQ-024 PLAY_USER: E2=1; if end_time go to RESULT, else if end_User go to CHECK. end_time has priority when both are high in the same cycle.
REQ-025 CHECK: all enables 0; if match go to NEXT_ROUND, else go to RESULT.
REQ-026 NEXT_ROUND: E4=1 and R2=1 for exactly one cycle; go to ROUND_CHK.
REQ-027 ROUND_CHK: all 0; this state gives win one cycle to settle after the increment. If win go to RESULT, else go to PLAY_FPGA.
REQ-028 RESULT: SEL=1; on press go to INIT, else hold indefinitely.
REQ-029 Outputs not listed for a state SHALL be 0.
REQ-030 A press in any state other than SETUP or RESULT SHALL be ignored and not stored.
REQ-031 Status inputs SHALL be sampled only in the states named above; status inputs asserted in any other state have no effect.
REQ-032 An unreachable or illegal state code SHALL transition to INIT on the next clock.

Reset
REQ-033 While reset_n=0: state=INIT, R1=1, R2=1, E1..E4=0, SEL=0, state_o=0, synchroniser flops=1 (released key), edge detector armed.
REQ-034 Assertion mid-operation SHALL take effect immediately, without waiting for a clock edge; the FSM resumes at INIT→SETUP after release.
REQ-035 A key held through reset release SHALL NOT generate a press.

Structure
REQ-036 State codes (INIT..RESULT) SHALL be localparams in the shared package/header genius_pkg, also used by the display/debug logic.
REQ-037 Synchroniser plus edge detector SHALL be one sub-module, key_press_detect (ports CLOCK_50, reset_n, key_n, press); the FSM SHALL be written inline.

Verification
REQ-038 Reset, release, idle 4 cycles -> state_o sequence 0,1,1,1; R1=R2=1 only in INIT; E1=1 in SETUP.
REQ-039 In SETUP, enter_n low for 20 cycles -> exactly one press, PLAY_FPGA reached 4 cycles after the fall, E3=1.
REQ-040 PLAY_USER with end_User=1 and end_time=1 in the same cycle -> next state RESULT, SEL=1, E2=0.
REQ-041 Full round: end_FPGA, end_User, match=1, win=0 -> CHECK, NEXT_ROUND (E4=R2=1 for one cycle), ROUND_CHK, PLAY_FPGA.
REQ-042 ROUND_CHK with win=1 -> RESULT; press -> INIT with R1=1.
REQ-043 reset_n pulsed low mid PLAY_USER, between clock edges -> outputs go to their reset values before the next edge.
